instr_boot_loader: RTL and testbench

Byte-stream boot loader that sits directly upstream of `single_cycle`. It assembles a little-endian byte stream into 32-bit instructions and drives the core's instruction-memory write port (`instr_in`, `instr_wr_addr`, `instr_wr_en`). It holds the core in reset until the whole program is written, then releases it. It replaces bench-side `$readmemb` preloading in FPGA bring-up.

---
 rtl/instr_boot_loader.sv | 155 +++++++++++++++
 tb/tb_instr_boot_loader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_boot_loader.sv
// Byte-stream boot loader: builds 32-bit little-endian words, writes them into single_cycle's
// instruction memory and holds the core in reset until loaded. Define BOOT_CHECKSUM_EN for a trailing XOR checksum byte.
module instr_boot_loader #(
    parameter  int WIDTH   = 32,
    parameter  int SIZE    = 64,
    localparam int LOGSIZE = $clog2(SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [WIDTH-1:0]     instr_in,
    output logic [LOGSIZE+1:0]   instr_wr_addr,
    output logic                 instr_wr_en,
    output logic                 cpu_reset,
    output logic                 done,
    output logic                 error,
    output logic [2:0]           dbg_state
);

    // Handshake: a byte transfers on the rising edge where byte_valid && byte_ready;
    // byte_ready is a pure decode of the state register and never looks at byte_valid.

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_FIN,
        S_RUN,
        S_ERR
`ifdef BOOT_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_FIN;
`endif

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [15:0] word_idx;
    logic [15:0] word_cnt;
    logic [23:0] partial;
    logic        accept;
    logic        word_done;
    logic        last_word;
    logic [15:0] hdr_count;

    assign accept    = byte_valid && byte_ready;
    assign word_done = (byte_cnt == 2'd3);
    assign last_word = (word_idx == word_cnt - 16'd1);
    assign hdr_count = {byte_in, word_cnt[7:0]};
    assign dbg_state = state;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every byte before the checksum itself, header included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'h00;
        end else if (accept && state != S_CHK) begin
            csum <= csum ^ byte_in;
        end
    end
`endif

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            S_HDR0, S_HDR1, S_DATA: byte_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            S_CHK:                  byte_ready = 1'b1;
`endif
            default:                byte_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HDR0: begin
                if (accept) state_next = S_HDR1;
            end
            S_HDR1: begin
                if (accept) begin
                    if ({16'd0, hdr_count} > 32'(SIZE)) state_next = S_ERR;
                    else if (hdr_count == 16'd0)        state_next = S_TAIL;
                    else                                state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && word_done && last_word) state_next = S_TAIL;
            end
            S_FIN: begin
                state_next = S_RUN;
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_next = (byte_in == csum) ? S_RUN : S_ERR;
            end
`endif
            default: begin
                state_next = state;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_HDR0;
            byte_cnt      <= 2'd0;
            word_idx      <= 16'd0;
            word_cnt      <= 16'd0;
            partial       <= 24'd0;
            instr_in      <= '0;
            instr_wr_addr <= '0;
            instr_wr_en   <= 1'b0;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state       <= state_next;
            instr_wr_en <= 1'b0;
            cpu_reset   <= (state_next != S_RUN);
            done        <= (state_next == S_RUN);
            error       <= (state_next == S_ERR);
            if (accept) begin
                case (state)
                    S_HDR0: word_cnt[7:0]  <= byte_in;
                    S_HDR1: word_cnt[15:8] <= byte_in;
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (word_done) begin
                            instr_in      <= {byte_in, partial};
                            instr_wr_addr <= {word_idx[LOGSIZE-1:0], 2'b00};
                            instr_wr_en   <= 1'b1;
                            word_idx      <= word_idx + 16'd1;
                        end else begin
                            // Bytes shift in from the top so byte 0 ends up in bits [7:0].
                            partial <= {byte_in, partial[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_boot_loader.sv
// Bench for instr_boot_loader: directed and randomized byte streams checked against a stream-level
// reference model. Build with +define+BOOT_CHECKSUM_EN to exercise the checksum variant.
`timescale 1ns/1ps
module tb_instr_boot_loader;

    localparam int WIDTH   = 32;
    localparam int SIZE    = 64;
    localparam int LOGSIZE = $clog2(SIZE);
    localparam int W       = LOGSIZE + 2 + WIDTH;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         byte_in = 8'h00;
    logic               byte_valid = 1'b0;
    logic               byte_ready;
    logic [WIDTH-1:0]   instr_in;
    logic [LOGSIZE+1:0] instr_wr_addr;
    logic               instr_wr_en;
    logic               cpu_reset;
    logic               done;
    logic               error;
    logic [2:0]         dbg_state;

    instr_boot_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .instr_in(instr_in), .instr_wr_addr(instr_wr_addr),
        .instr_wr_en(instr_wr_en), .cpu_reset(cpu_reset), .done(done), .error(error),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]   stim_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    int           exp_status;

    // Write monitor: every strobe seen mid-cycle becomes an observed {addr, data} entry.
    always @(negedge clk) begin
        if (!reset && instr_wr_en) begin
            got_q.push_back({instr_wr_addr, instr_in});
            got_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        byte_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        got_q.delete();
        got_cyc.delete();
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in = b;
        guard = 0;
        while (!byte_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_all(input int gap_max);
        foreach (stim_q[i]) send_byte(stim_q[i], int'($urandom_range(gap_max, 0)));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic add_checksum();
        logic [7:0] x;
        x = 8'h00;
        foreach (stim_q[i]) x ^= stim_q[i];
        stim_q.push_back(x);
    endtask

    task automatic build_prog(input int n, input bit corrupt);
        stim_q.delete();
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        if (n <= SIZE) begin
            for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
`ifdef BOOT_CHECKSUM_EN
            add_checksum();
            if (corrupt) stim_q[stim_q.size() - 1] ^= 8'h5a;
`endif
        end
    endtask

    // ---------------- reference model ----------------
    // Reads the whole stream: word w is bytes 2+4w..5+4w little-endian at byte address 4w.
    task automatic model_expect();
        int n;
        logic [LOGSIZE+1:0] a;
        logic [7:0] x;
        exp_q.delete();
        exp_status = ST_DONE;
        n = int'({stim_q[1], stim_q[0]});
        if (n > SIZE) begin
            exp_status = ST_ERR;
            return;
        end
        for (int w = 0; w < n; w++) begin
            a = (LOGSIZE + 2)'(w * 4);
            exp_q.push_back({a, stim_q[4*w+5], stim_q[4*w+4], stim_q[4*w+3], stim_q[4*w+2]});
        end
`ifdef BOOT_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < stim_q.size() - 1; i++) x ^= stim_q[i];
        if (x != stim_q[stim_q.size() - 1]) exp_status = ST_ERR;
`endif
    endtask

    task automatic load_test2_stream();
        stim_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        add_checksum();
`endif
        exp_q = '{{8'h00, 32'h00500513}, {8'h04, 32'h00A00593}};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        repeat (20) @(negedge clk);
        n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_byte_ready: got %b want 1", byte_ready); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (instr_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", instr_wr_en); end
        n_cmp++; if (instr_in !== '0) begin n_fail++; $display("FAIL reset_instr_in: got %h want 0", instr_in); end
        n_cmp++; if (instr_wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0", instr_wr_addr); end
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_no_writes: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_directed();
        load_test2_stream();
        do_reset();
        send_all(0);
        @(negedge clk);
        byte_valid = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL dir_done_after_chk: got %b want 1", done); end
        n_cmp++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL dir_release_after_chk: got %b want 0", cpu_reset); end
`else
        n_cmp++; if (instr_wr_en !== 1'b1) begin n_fail++; $display("FAIL dir_fin_strobe: got %b want 1", instr_wr_en); end
        n_cmp++; if (instr_in !== 32'h00A00593) begin n_fail++; $display("FAIL dir_fin_data: got %h want 00a00593", instr_in); end
        n_cmp++; if (instr_wr_addr !== 8'd4) begin n_fail++; $display("FAIL dir_fin_addr: got %0d want 4", instr_wr_addr); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL dir_fin_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir_fin_done: got %b want 0", done); end
        @(negedge clk);
        n_cmp++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL dir_run_cpu_reset: got %b want 0", cpu_reset); end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL dir_run_done: got %b want 1", done); end
        n_cmp++; if (instr_wr_en !== 1'b0) begin n_fail++; $display("FAIL dir_run_wr_en: got %b want 0", instr_wr_en); end
`endif
        n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL dir_run_byte_ready: got %b want 0", byte_ready); end
        idle(4);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL dir_write_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL dir_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        for (int rep = 0; rep < 3; rep++) begin
            load_test2_stream();
            do_reset();
            send_all(5);
            idle(5);
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL gaps_write_count: got %0d want %0d", got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gaps_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got %b want 1", done); end
        end
    endtask

    task automatic test_overflow();
        stim_q = '{8'h41, 8'h00};
        do_reset();
        send_all(0);
        @(negedge clk);
        byte_valid = 1'b0;
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error: got %b want 1", error); end
        n_cmp++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_byte_ready: got %b want 0", byte_ready); end
        repeat (10) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
        end
        byte_valid = 1'b0;
        n_cmp++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL ovf_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL ovf_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error_held: got %b want 1", error); end
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_writes: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_mid_reset();
        load_test2_stream();
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_byte_ready: got %b want 1", byte_ready); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL mid_rst_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (instr_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_en: got %b want 0", instr_wr_en); end
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_rst_partial_written: got %0d want 0", got_q.size()); end
        send_all(2);
        idle(5);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_rst_write_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_rst_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_rst_done: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        build_prog(SIZE, 1'b0);
        model_expect();
        do_reset();
        send_all(0);
        idle(5);
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_write_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_cmp++; if (got_cyc[i] - got_cyc[i-1] != 4) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 4", i, got_cyc[i] - got_cyc[i-1]); end
        end
        n_cmp++; if (done !== (exp_status == ST_DONE)) begin n_fail++; $display("FAIL b2b_done: got %b want %b", done, exp_status == ST_DONE); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(4, 0) == 0) n = SIZE + 1 + int'($urandom_range(10, 0));
            else n = int'($urandom_range(10, 0));
            build_prog(n, $urandom_range(3, 0) == 0);
            model_expect();
            do_reset();
            send_all(3);
            idle(5);
            n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_write_count: got %0d want %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_write[%0d]: got %h want %h", it, i, got_q[i], exp_q[i]); end
            end
            n_cmp++; if (done !== (exp_status == ST_DONE)) begin n_fail++; $display("FAIL rnd%0d_done: got %b want %b", it, done, exp_status == ST_DONE); end
            n_cmp++; if (error !== (exp_status == ST_ERR)) begin n_fail++; $display("FAIL rnd%0d_error: got %b want %b", it, error, exp_status == ST_ERR); end
            n_cmp++; if (cpu_reset !== (exp_status != ST_DONE)) begin n_fail++; $display("FAIL rnd%0d_cpu_reset: got %b want %b", it, cpu_reset, exp_status != ST_DONE); end
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        stim_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
        do_reset();
        send_all(0);
        idle(4);
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL chk_ok_write_count: got %0d want 1", got_q.size()); end
        else begin
            n_cmp++; if (got_q[0] !== {8'h00, 32'h00000013}) begin n_fail++; $display("FAIL chk_ok_write: got %h want 0000000013", got_q[0]); end
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL chk_ok_done: got %b want 1", done); end
        stim_q[6] = 8'h13;
        do_reset();
        send_all(0);
        idle(4);
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL chk_bad_error: got %b want 1", error); end
        n_cmp++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL chk_bad_cpu_reset: got %b want 1", cpu_reset); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL chk_bad_done: got %b want 0", done); end
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL chk_bad_write_kept: got %0d want 1", got_q.size()); end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_gaps();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
